// File: rtl/fifo_ctrl_param_if.sv
// Producer/consumer bus for fifo_ctrl_param. The FIFO uses the slave modport
// and the producer/consumer side uses the master modport.
interface fifo_ctrl_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) ();
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  modport slave (
    input  wr_en, din, rd_en,
    output dout, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

  modport master (
    output wr_en, din, rd_en,
    input  dout, data_count, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO with occupancy flags and registered ack/err handshakes.
// Define FIFO_CTRL_CLR_EN to add a synchronous flush input 'clr'.
module fifo_ctrl_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic clk,
  input logic reset,
`ifdef FIFO_CTRL_CLR_EN
  input logic clr,
`endif
  fifo_ctrl_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];

  generate
    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_badLevels
      $error("fifo_ctrl_param: illegal levels, need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_tail;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_wrAck;
  logic                  r_wrErr;
  logic                  r_rdAck;
  logic                  r_rdErr;

  logic w_full;
  logic w_empty;
  logic w_wrOk;
  logic w_rdOk;
  logic w_clr;

`ifdef FIFO_CTRL_CLR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);
  // A write to a full FIFO is fine when a read frees the oldest slot in the same edge.
  assign w_wrOk  = bus.wr_en & (~w_full | bus.rd_en);
  assign w_rdOk  = bus.rd_en & ~w_empty;

  // Storage has no reset; reset and flush still block writes in their cycle.
  always_ff @(posedge clk) begin
    if (!reset && !w_clr && w_wrOk) begin
      r_mem[r_tail] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_wrAck <= 1'b0;
      r_wrErr <= 1'b0;
      r_rdAck <= 1'b0;
      r_rdErr <= 1'b0;
    end else if (w_clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_wrAck <= 1'b0;
      r_wrErr <= 1'b0;
      r_rdAck <= 1'b0;
      r_rdErr <= 1'b0;
    end else begin
      if (w_wrOk) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_rdOk) begin
        r_dout <= r_mem[r_head];
        r_head <= r_head + 1'b1;
      end
      case ({w_wrOk, w_rdOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wrAck <= w_wrOk;
      r_wrErr <= bus.wr_en & ~w_wrOk;
      r_rdAck <= w_rdOk;
      r_rdErr <= bus.rd_en & ~w_rdOk;
    end
  end

  assign bus.dout         = r_dout;
  assign bus.data_count   = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_CNT);
  assign bus.almost_empty = (r_count <= AE_CNT);
  assign bus.wr_ack       = r_wrAck;
  assign bus.wr_err       = r_wrErr;
  assign bus.rd_ack       = r_rdAck;
  assign bus.rd_err       = r_rdErr;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed self-checking bench for fifo_ctrl_param (8 deep, 32 bit).
// Exercises the clr flush too when built with FIFO_CTRL_CLR_EN.
module tb_fifo_ctrl_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef FIFO_CTRL_CLR_EN
  logic clr = 1'b0;
`endif
  int total = 0;
  int bad = 0;

  fifo_ctrl_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  fifo_ctrl_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef FIFO_CTRL_CLR_EN
    .clr   (clr),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests, let the edge happen, then sample 1 ns later.
  task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic rd);
    bus.wr_en = wr;
    bus.din   = d;
    bus.rd_en = rd;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;

    // Reset then idle
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rst_count", 32'(bus.data_count), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_aempty", 32'(bus.almost_empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_dout", bus.dout, 32'd0);
    checkOutput("rst_acks", {28'd0, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, 32'd0);

    // Fill with 0x11..0x88
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 32'h11 * k, 1'b0);
      checkOutput("fill_ack", 32'(bus.wr_ack), 32'd1);
      checkOutput("fill_count", 32'(bus.data_count), 32'(k));
      checkOutput("fill_afull", 32'(bus.almost_full), (k >= 6) ? 32'd1 : 32'd0);
      checkOutput("fill_full", 32'(bus.full), (k == 8) ? 32'd1 : 32'd0);
      checkOutput("fill_aempty", 32'(bus.almost_empty), (k <= 2) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 32'h99, 1'b0);
    checkOutput("ovf_err", 32'(bus.wr_err), 32'd1);
    checkOutput("ovf_ack", 32'(bus.wr_ack), 32'd0);
    checkOutput("ovf_count", 32'(bus.data_count), 32'd8);

    // Drain in order
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("drain_dout", bus.dout, 32'h11 * k);
      checkOutput("drain_ack", 32'(bus.rd_ack), 32'd1);
      checkOutput("drain_count", 32'(bus.data_count), 32'(8 - k));
      checkOutput("drain_empty", 32'(bus.empty), (k == 8) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("udf_err", 32'(bus.rd_err), 32'd1);
    checkOutput("udf_ack", 32'(bus.rd_ack), 32'd0);
    checkOutput("udf_dout", bus.dout, 32'h88);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("idle_err", 32'(bus.rd_err), 32'd0);

    // Pointer wrap: 5 in/out, then 8 in/out crossing the wrap point
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 32'h20 + k, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("wrap5_dout", bus.dout, 32'h20 + k);
    end
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 32'h30 + k, 1'b0);
    checkOutput("wrap8_count", 32'(bus.data_count), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("wrap8_dout", bus.dout, 32'h30 + k);
    end
    checkOutput("wrap_count", 32'(bus.data_count), 32'd0);

    // Full plus simultaneous read and write
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 32'h40 + k, 1'b0);
    applyStimulus(1'b1, 32'hAA, 1'b1);
    checkOutput("fullrw_dout", bus.dout, 32'h41);
    checkOutput("fullrw_wack", 32'(bus.wr_ack), 32'd1);
    checkOutput("fullrw_rack", 32'(bus.rd_ack), 32'd1);
    checkOutput("fullrw_count", 32'(bus.data_count), 32'd8);
    for (int k = 2; k <= 8; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("fullrw_drain", bus.dout, 32'h40 + k);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("fullrw_last", bus.dout, 32'hAA);

    // Empty plus simultaneous read and write: no bypass
    applyStimulus(1'b1, 32'hBB, 1'b1);
    checkOutput("emptyrw_wack", 32'(bus.wr_ack), 32'd1);
    checkOutput("emptyrw_rerr", 32'(bus.rd_err), 32'd1);
    checkOutput("emptyrw_rack", 32'(bus.rd_ack), 32'd0);
    checkOutput("emptyrw_count", 32'(bus.data_count), 32'd1);
    checkOutput("emptyrw_dout", bus.dout, 32'hAA);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("emptyrw_read", bus.dout, 32'hBB);

    // Reset mid-stream beats a write in the same cycle
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 32'h60 + k, 1'b0);
    checkOutput("mid_count5", 32'(bus.data_count), 32'd5);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h99, 1'b0);
    reset = 1'b0;
    checkOutput("mid_count", 32'(bus.data_count), 32'd0);
    checkOutput("mid_empty", 32'(bus.empty), 32'd1);
    checkOutput("mid_wack", 32'(bus.wr_ack), 32'd0);
    checkOutput("mid_dout", bus.dout, 32'd0);
    applyStimulus(1'b1, 32'h55, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("mid_read", bus.dout, 32'h55);
    checkOutput("mid_rack", 32'(bus.rd_ack), 32'd1);

`ifdef FIFO_CTRL_CLR_EN
    // Flush beats a write in the same cycle and leaves dout alone
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 32'h70 + k, 1'b0);
    clr = 1'b1;
    applyStimulus(1'b1, 32'h77, 1'b0);
    clr = 1'b0;
    checkOutput("clr_count", 32'(bus.data_count), 32'd0);
    checkOutput("clr_wack", 32'(bus.wr_ack), 32'd0);
    checkOutput("clr_dout", bus.dout, 32'h55);
    applyStimulus(1'b1, 32'h56, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("clr_read", bus.dout, 32'h56);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
- Parametrised synchronous FIFO: registered head/tail pointers, occupancy counter and storage array.
- Next generation of the team's fixed 8-deep, one-operation-per-cycle FIFO pointer logic.
- Generalised in depth and width. Accepts simultaneous read and write in one cycle.
- Adds almost-full/almost-empty flags and per-operation ack/error handshakes.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
DATA_WIDTH, 32, width of each data word
ADDR_WIDTH, 3, pointer width; depth DEPTH = 2**ADDR_WIDTH
AF_LEVEL, 6, almost_full asserted when data_count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when data_count <= AE_LEVEL

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write request, sampled each rising edge
din  input  DATA_WIDTH  write data
rd_en  input  1  read request, sampled each rising edge
dout  output  DATA_WIDTH  registered read data
data_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
full  output  1  data_count == DEPTH
empty  output  1  data_count == 0
almost_full  output  1  data_count >= AF_LEVEL
almost_empty  output  1  data_count <= AE_LEVEL
wr_ack  output  1  previous-cycle write accepted
wr_err  output  1  previous-cycle write rejected (overflow)
rd_ack  output  1  previous-cycle read accepted; dout valid
rd_err  output  1  previous-cycle read rejected (underflow)

Behaviour:
- Reset (reset=1 at a rising edge):
  - head=0, tail=0, data_count=0, dout=0.
  - All ack/err outputs 0.
  - Storage contents unchanged (don't-care).
  - Reset wins over every request in the same cycle, including mid-stream.
- State: registered head (read pointer) and tail (write pointer), each ADDR_WIDTH bits, plus data_count.
  - Pointers wrap modulo DEPTH by natural overflow; no comparison logic.
- Acceptance, evaluated on pre-edge state:
  - wr_ok = wr_en & (!full | rd_en).
  - rd_ok = rd_en & !empty.
- Accepted write: mem[tail] <= din; tail <= tail+1.
- Accepted read: dout <= mem[head]; head <= head+1.
- dout holds its value when no read is accepted.
- Count update:
  - wr_ok only: data_count +1.
  - rd_ok only: data_count -1.
  - Both, or neither: unchanged.
- Simultaneous events:
  - Full with rd_en & wr_en: both accepted. Read returns the oldest word; write fills the freed slot; data_count stays DEPTH.
  - Empty with rd_en & wr_en: write accepted, read rejected (rd_err=1). No write-through bypass.
- Handshakes are registered, valid the cycle after the request edge, and pulse for one cycle per request:
  - wr_ack=wr_ok; wr_err=wr_en & !wr_ok.
  - rd_ack=rd_ok; rd_err=rd_en & !rd_ok.
- Rejected operations change no pointer, count or storage.
- Flags (full, empty, almost_full, almost_empty) are combinational decodes of registered data_count, so they are glitch-free relative to clk.
- Read latency: 1 cycle (rd_ok at edge N, dout valid after edge N).
- Write-to-read latency: a word written at edge N is readable by a request sampled at edge N+1.
- Invariants:
  - data_count never exceeds DEPTH and never underflows.
  - (tail - head) mod DEPTH == data_count mod DEPTH.
- Parameter legality: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH; violations are a configuration error (simulation $error at time 0).

Optional Feature:
- Macro: FIFO_CTRL_CLR_EN.
- When defined:
  - Extra input port clr (1 bit) follows reset.
  - Synchronous flush: head, tail and data_count go to 0, and all ack/err go to 0 at the next edge.
  - dout holds its value.
  - clr has priority over wr_en/rd_en in the same cycle; reset has priority over clr.
- When undefined: no clr port; only reset empties the FIFO.

Test Plan:
- Reset, then idle -> data_count=0, empty=1, almost_empty=1, full=0, dout=0, all ack/err=0.
- DEPTH=8: write 0x11..0x88 on 8 consecutive cycles -> wr_ack each cycle, full=1 after 8th, almost_full from count 6. 9th write 0x99 -> wr_err=1, count stays 8.
- From full, read 8 times -> dout sequence 0x11..0x88, rd_ack each, empty after last. Extra read -> rd_err=1, dout holds 0x88.
- Pointer wrap: 5 writes, 5 reads, then 8 writes and 8 reads -> data order preserved across tail/head wrap, count returns to 0.
- Full plus simultaneous rd_en & wr_en (din=0xAA) -> dout=oldest word, wr_ack=rd_ack=1, count stays 8. Empty plus both -> wr_ack=1, rd_err=1, count=1.
- Reset asserted mid-burst with count=5 -> next cycle count=0, empty=1; subsequent write/read of 0x55 returns 0x55. With FIFO_CTRL_CLR_EN, the same check via clr with wr_en=1 in the same cycle -> count=0, no wr_ack.
